// File: rtl/pconv_sched_c6.sv
// rtl/pconv_sched_c6.sv - sequencer for a 6-channel pointwise convolution layer
//
// Walks every output channel (outer) and pixel (inner). For each it fetches the
// packed feature word, weight word and bias/shift, issues one vector to the
// pconv unit, waits for the result and writes it to the output buffer.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start / busy / done   layer handshake; done pulses on completion or abort
//   err                   sticky timeout flag, cleared by the next accepted start
//   fm_rd, fm_raddr       feature read (data 1 cycle later on fm_rdata)
//   w_raddr / w_rdata     weight read (1-cycle latency)
//   p_raddr / p_bias / p_shift   per-channel parameter read (1-cycle latency)
//   pu_input_vld, pu_*_din       operands and issue strobe to the unit
//   pu_conv_dout(_vld)    unit result
//   out_we, out_waddr, out_wdata output buffer write port
module pconv_sched_c6 #(
  parameter int N        = 16,
  parameter int IMG_SIZE = 12,
  parameter int OUT_CH   = 16,
  parameter int FM_AW    = 8,
  parameter int OC_AW    = 4,
  parameter int OUT_AW   = 12,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              fm_rd,
  output logic [FM_AW-1:0]  fm_raddr,
  input  logic [6*N-1:0]    fm_rdata,
  output logic [OC_AW-1:0]  w_raddr,
  input  logic [6*N-1:0]    w_rdata,
  output logic [OC_AW-1:0]  p_raddr,
  input  logic [31:0]       p_bias,
  input  logic [4:0]        p_shift,
  output logic              pu_input_vld,
  output logic [6*N-1:0]    pu_input_din,
  output logic [6*N-1:0]    pu_weight_din,
  output logic [31:0]       pu_bias_din,
  output logic [4:0]        pu_shift_din,
  input  logic [N-1:0]      pu_conv_dout,
  input  logic              pu_conv_dout_vld,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_waddr,
  output logic [N-1:0]      out_wdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam int                PIX      = IMG_SIZE * IMG_SIZE;
  localparam logic [FM_AW-1:0]  PIX_LAST = FM_AW'(PIX - 1);
  localparam logic [OC_AW-1:0]  OC_LAST  = OC_AW'(OUT_CH - 1);
  localparam int                TO_W     = $clog2(TIMEOUT + 1);
  // The count "reaches TIMEOUT" on the increment made while it holds TIMEOUT-1.
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [2:0]        nxt;
  logic [OC_AW-1:0]  oc;
  logic [FM_AW-1:0]  pix;
  logic [OUT_AW-1:0] wcnt;
  logic [TO_W-1:0]   tcnt;
  logic              last_out;
  logic              to_hit;

  assign last_out = (oc == OC_LAST) && (pix == PIX_LAST);
  // A valid in the same cycle as the final count takes priority over the abort.
  assign to_hit   = !pu_conv_dout_vld && (tcnt == TO_LAST);

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_FETCH;
      S_FETCH: nxt = S_ISSUE;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (pu_conv_dout_vld) nxt = S_WRITE;
        else if (to_hit)      nxt = S_FIN;
      end
      S_WRITE: nxt = last_out ? S_FIN : S_DRAIN;
      // Hold until the previous valid drops so a long valid is not taken twice.
      S_DRAIN: if (!pu_conv_dout_vld) nxt = S_FETCH;
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each is high exactly while
  // the FSM sits in the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      fm_rd         <= 1'b0;
      fm_raddr      <= '0;
      w_raddr       <= '0;
      p_raddr       <= '0;
      pu_input_vld  <= 1'b0;
      pu_input_din  <= '0;
      pu_weight_din <= '0;
      pu_bias_din   <= '0;
      pu_shift_din  <= '0;
      out_we        <= 1'b0;
      out_waddr     <= '0;
      out_wdata     <= '0;
      oc            <= '0;
      pix           <= '0;
      wcnt          <= '0;
      tcnt          <= '0;
    end else begin
      state        <= nxt;
      busy         <= (nxt != S_IDLE);
      done         <= (nxt == S_FIN);
      fm_rd        <= (nxt == S_FETCH);
      pu_input_vld <= (nxt == S_ISSUE);
      out_we       <= (nxt == S_WRITE);

      case (state)
        S_IDLE: begin
          if (start) begin
            oc       <= '0;
            pix      <= '0;
            wcnt     <= '0;
            err      <= 1'b0;
            fm_raddr <= '0;
            w_raddr  <= '0;
            p_raddr  <= '0;
          end
        end
        S_ISSUE: begin
          // Memory data for the FETCH addresses is valid now; operands stay
          // frozen until the next ISSUE because the unit may sample late.
          pu_input_din  <= fm_rdata;
          pu_weight_din <= w_rdata;
          pu_bias_din   <= p_bias;
          pu_shift_din  <= p_shift;
          tcnt          <= '0;
        end
        S_WAIT: begin
          if (pu_conv_dout_vld) begin
            out_waddr <= wcnt;
            out_wdata <= pu_conv_dout;
          end else if (to_hit) begin
            err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WRITE: begin
          // wcnt tracks oc*PIX+pix, so no multiplier is needed for the address.
          wcnt <= wcnt + 1'b1;
          if (!last_out) begin
            if (pix == PIX_LAST) begin
              pix <= '0;
              oc  <= oc + 1'b1;
            end else begin
              pix <= pix + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!pu_conv_dout_vld) begin
            fm_raddr <= pix;
            w_raddr  <= oc;
            p_raddr  <= oc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
